// File: rtl/rom_burst_reader.sv
// Burst reader for a constant-content ROM (word[a] = a + SEED) with a registered read port.
// After a start request it streams burst_len+1 consecutive words under valid/ready flow control.
module rom_burst_reader #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 4,
   parameter int SEED       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] burst_len,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] d_out,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic                  last,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      STREAM
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH-1:0] remain;
   logic                  xfer;
   logic                  final_xfer;
   logic                  accept;
   logic                  load_word;

   function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
      logic [31:0] sum;
      sum = 32'(a) + 32'(SEED);
      return sum[DATA_WIDTH-1:0];
   endfunction

   assign xfer       = out_valid && out_ready;
   assign final_xfer = (state == STREAM) && xfer && last;
   assign busy       = (state != IDLE);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      load_word = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            load_word = 1'b1;
            state_nxt = STREAM;
         end
         STREAM: begin
            if (xfer) begin
               if (last) state_nxt = IDLE;
               else      load_word = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // rd_addr runs one word ahead of addr_out so a word can be delivered every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr   <= '0;
         remain    <= '0;
         out_valid <= 1'b0;
         d_out     <= '0;
         addr_out  <= '0;
         last      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= final_xfer;
         if (accept) begin
            rd_addr <= base_addr;
            remain  <= burst_len;
         end
         if (load_word) begin
            d_out     <= rom_word(rd_addr);
            addr_out  <= rd_addr;
            last      <= (remain == '0);
            rd_addr   <= rd_addr + ADDR_WIDTH'(1);
            remain    <= remain - ADDR_WIDTH'(1);
            out_valid <= 1'b1;
         end else if (final_xfer) begin
            out_valid <= 1'b0;
            last      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: two instances (SEED=3 and SEED=0) share stimulus and are
// compared cycle by cycle against a queue-based burst model.
module tb_rom_burst_reader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       out_ready = 1'b0;
   logic [3:0] base_addr = '0;
   logic [3:0] burst_len = '0;

   logic       v3, l3, b3, dn3, v0, l0, b0, dn0;
   logic [3:0] d3, a3, d0, a0;
   logic [23:0] all_outs;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic       v;
      logic       l;
      logic       b;
      logic       dn;
      logic [3:0] a;
      logic [3:0] d3;
      logic [3:0] d0;
   } samp_t;

   samp_t obs_q[$];
   samp_t exp_q[$];

   rom_burst_reader #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .SEED(3)) u_dut_s3 (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .burst_len(burst_len),
      .out_ready(out_ready), .out_valid(v3), .d_out(d3), .addr_out(a3), .last(l3),
      .busy(b3), .done(dn3)
   );

   rom_burst_reader #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .SEED(0)) u_dut_s0 (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .burst_len(burst_len),
      .out_ready(out_ready), .out_valid(v0), .d_out(d0), .addr_out(a0), .last(l0),
      .busy(b0), .done(dn0)
   );

   assign all_outs = {v3, d3, a3, l3, b3, dn3, v0, d0, a0, l0, b0, dn0};

   always #5 clk = ~clk;

   // Word, address and last only carry meaning while valid.
   function automatic samp_t mask_samp(samp_t s);
      samp_t r;
      r = s;
      if (!r.v) begin
         r.l  = 1'b0;
         r.a  = '0;
         r.d3 = '0;
         r.d0 = '0;
      end
      return r;
   endfunction

   // Start bit i launches a burst with (b_first,l_first) at i==0, else (b_rest,l_rest).
   task automatic capture(input int n, input logic [127:0] rb, input logic [127:0] sb,
                          input logic [3:0] b_first, input logic [3:0] l_first,
                          input logic [3:0] b_rest, input logic [3:0] l_rest);
      samp_t s;
      obs_q.delete();
      for (int i = 0; i < n; i++) begin
         out_ready = rb[i];
         start     = sb[i];
         if (sb[i]) begin
            base_addr = (i == 0) ? b_first : b_rest;
            burst_len = (i == 0) ? l_first : l_rest;
         end else begin
            base_addr = 4'($urandom);
            burst_len = 4'($urandom);
         end
         @(negedge clk);
         s.v  = v3;
         s.l  = l3;
         s.b  = b3;
         s.dn = dn3;
         s.a  = a3;
         s.d3 = d3;
         s.d0 = d0;
         obs_q.push_back(mask_samp(s));
         @(posedge clk);
         #1;
      end
      start = 1'b0;
   endtask

   // Burst-level reference: a queue of pending addresses, one-cycle fetch gap, done after the last pop.
   task automatic model_run(input int n, input logic [127:0] rb, input logic [127:0] sb,
                            input logic [3:0] b_first, input logic [3:0] l_first,
                            input logic [3:0] b_rest, input logic [3:0] l_rest);
      logic [3:0] pend[$];
      bit         fetching;
      bit         done_now;
      samp_t      s;
      int         blen;
      logic [3:0] bbase;
      fetching = 1'b0;
      done_now = 1'b0;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         s    = '0;
         s.b  = fetching || (pend.size() != 0);
         s.v  = !fetching && (pend.size() != 0);
         s.dn = done_now;
         if (s.v) begin
            s.a  = pend[0];
            s.d3 = pend[0] + 4'd3;
            s.d0 = pend[0];
            s.l  = (pend.size() == 1);
         end
         exp_q.push_back(s);
         done_now = 1'b0;
         if (fetching) begin
            fetching = 1'b0;
         end else if (pend.size() != 0) begin
            if (rb[i]) begin
               void'(pend.pop_front());
               if (pend.size() == 0) done_now = 1'b1;
            end
         end else if (sb[i]) begin
            fetching = 1'b1;
            bbase    = (i == 0) ? b_first : b_rest;
            blen     = int'((i == 0) ? l_first : l_rest);
            for (int k = 0; k <= blen; k++) pend.push_back(4'(int'(bbase) + k));
         end
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if (all_outs !== 24'h0) begin
         n_err++;
         $display("FAIL reset_async: outputs %h, expected %h", all_outs, 24'h0);
      end
      @(negedge clk);
      n_vec++;
      if (all_outs !== 24'h0) begin
         n_err++;
         $display("FAIL reset_held: outputs %h, expected %h", all_outs, 24'h0);
      end
   endtask

   task automatic test_first_start();
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_run(5, '1, 128'h1, 4'd7, 4'd0, 4'd0, 4'd0);
      capture(5, '1, 128'h1, 4'd7, 4'd0, 4'd0, 4'd0);
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL first_start[%0d]: got %h expected %h (v,last,busy,done,addr,d3,d0)",
                     i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_full_sweep();
      model_run(20, '1, 128'h1, 4'd0, 4'd15, 4'd0, 4'd0);
      capture(20, '1, 128'h1, 4'd0, 4'd15, 4'd0, 4'd0);
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL sweep[%0d]: got %h expected %h (v,last,busy,done,addr,d3,d0)",
                     i, obs_q[i], exp_q[i]);
         end
      end
      // Spot check of the 16th word directly from the content rule.
      n_vec++;
      if (obs_q[17] !== samp_t'({1'b1, 1'b1, 1'b1, 1'b0, 4'd15, 4'd2, 4'd15})) begin
         n_err++;
         $display("FAIL sweep_last_word: got %h expected v/last addr 15 d3 2", obs_q[17]);
      end
   endtask

   task automatic test_wrap();
      model_run(8, '1, 128'h1, 4'd14, 4'd3, 4'd0, 4'd0);
      capture(8, '1, 128'h1, 4'd14, 4'd3, 4'd0, 4'd0);
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL wrap[%0d]: got %h expected %h (v,last,busy,done,addr,d3,d0)",
                     i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] rb;
      rb = ~128'h38;
      model_run(10, rb, 128'h1, 4'd5, 4'd2, 4'd0, 4'd0);
      capture(10, rb, 128'h1, 4'd5, 4'd2, 4'd0, 4'd0);
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL backpressure[%0d]: got %h expected %h (v,last,busy,done,addr,d3,d0)",
                     i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] sb;
      sb = 128'h49;
      model_run(11, '1, sb, 4'd4, 4'd3, 4'd9, 4'd0);
      capture(11, '1, sb, 4'd4, 4'd3, 4'd9, 4'd0);
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL back_to_back[%0d]: got %h expected %h (v,last,busy,done,addr,d3,d0)",
                     i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      model_run(4, '1, 128'h1, 4'd10, 4'd5, 4'd0, 4'd0);
      capture(4, '1, 128'h1, 4'd10, 4'd5, 4'd0, 4'd0);
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL pre_abort[%0d]: got %h expected %h (v,last,busy,done,addr,d3,d0)",
                     i, obs_q[i], exp_q[i]);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (all_outs !== 24'h0) begin
         n_err++;
         $display("FAIL abort_async: outputs %h, expected %h", all_outs, 24'h0);
      end
      @(negedge clk);
      n_vec++;
      if (all_outs !== 24'h0) begin
         n_err++;
         $display("FAIL abort_held: outputs %h, expected %h", all_outs, 24'h0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_run(6, '1, 128'h1, 4'd2, 4'd1, 4'd0, 4'd0);
      capture(6, '1, 128'h1, 4'd2, 4'd1, 4'd0, 4'd0);
      foreach (exp_q[i]) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL post_abort[%0d]: got %h expected %h (v,last,busy,done,addr,d3,d0)",
                     i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [127:0] rb, sb;
      logic [3:0]   bf, lf, br, lr;
      for (int it = 0; it < 8; it++) begin
         rb = '0;
         sb = 128'h1;
         for (int i = 0; i < 128; i++) begin
            rb[i] = ($urandom_range(99) < 70);
            if (i > 0) sb[i] = ($urandom_range(99) < 15);
         end
         bf = 4'($urandom);
         lf = 4'($urandom);
         br = 4'($urandom);
         lr = 4'($urandom);
         rst_n = 1'b0;
         #1 rst_n = 1'b1;
         model_run(120, rb, sb, bf, lf, br, lr);
         capture(120, rb, sb, bf, lf, br, lr);
         foreach (exp_q[i]) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL random%0d[%0d]: got %h expected %h (v,last,busy,done,addr,d3,d0)",
                        it, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_start();
      test_full_sweep();
      test_wrap();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_burst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rom_burst_reader.md
ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, meaning ROM word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning ROM address width; depth = 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter SEED, default 0, meaning content offset: word[a] = (a + SEED) mod 2**DATA_WIDTH.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  burst request, sampled on rising clk.
REQ-007 base_addr  input  ADDR_WIDTH  first address of the burst.
REQ-008 burst_len  input  ADDR_WIDTH  burst length minus one (words = burst_len+1, range 1..2**ADDR_WIDTH).
REQ-009 out_ready  input  1  consumer accepts current word.
REQ-010 out_valid  output  1  d_out/addr_out/last hold a valid word.
REQ-011 d_out  output  DATA_WIDTH  ROM word at addr_out.
REQ-012 addr_out  output  ADDR_WIDTH  address of the word on d_out.
REQ-013 last  output  1  current word is the final word of the burst.
REQ-014 busy  output  1  burst in progress (state != IDLE).
REQ-015 done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, STREAM; busy = 1 in FETCH and STREAM only.
REQ-017 In IDLE, start=1 at a rising edge SHALL latch base_addr and burst_len, present base_addr to the ROM, and move to FETCH.
REQ-018 The ROM read SHALL be registered (1 cycle); FETCH SHALL last exactly one cycle and then move to STREAM with out_valid=1, so the first word is valid in the second cycle after the start-sampling edge.
REQ-019 A transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-020 While out_valid=1 and out_ready=0, d_out, addr_out and last SHALL hold stable.
REQ-021 On a non-final transfer, the next word (addr_out+1) SHALL be valid in the immediately following cycle, giving one word per cycle under continuous out_ready=1.
REQ-022 Address increment SHALL wrap modulo 2**ADDR_WIDTH (max address -> 0).
REQ-023 last SHALL be 1 exactly while the (burst_len+1)-th word is presented.
REQ-024 On the final transfer the block SHALL return to IDLE; in the next cycle out_valid=0, busy=0, done=1 for exactly one cycle.
REQ-025 start while busy=1 SHALL be ignored with no effect on the burst in progress.
REQ-026 start in the cycle done=1 SHALL be accepted (back-to-back bursts).
REQ-027 burst_len = 2**ADDR_WIDTH-1 SHALL read every address once, ending at base_addr-1 (wrapped).
REQ-028 base_addr and burst_len changes while busy SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, force state IDLE and out_valid, d_out, addr_out, last, busy, done to 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release the block SHALL accept a new start normally.
REQ-031 start asserted in the first rising edge after rst_n release SHALL be accepted.

Verification
REQ-032 Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 before next clk edge.
REQ-033 Full sweep, SEED=3, base=0, len=15, out_ready=1 -> 16 consecutive words d_out 3,4,...,15,0,1,2, addr_out 0..15, last on 16th, done one cycle later.
REQ-034 Wrap, SEED=0, base=14, len=3 -> addr_out 14,15,0,1, d_out 14,15,0,1, last on addr 1.
REQ-035 Backpressure, base=5, len=2, out_ready=0 for 3 cycles while word 2 presented -> addr_out=6/d_out=6+SEED held stable 3 cycles, then 7 follows.
REQ-036 start pulsed during burst (base=9) -> ignored; start in done cycle with base=9, len=0 -> single word addr 9, last=1, second done pulse.
REQ-037 Reset after 2nd transfer of a 6-word burst -> outputs 0, no done; new burst base=2, len=1 afterwards yields addr 2,3.
